// File: rtl/rvm_control_seq_pkg.sv
// Shared encodings for the main control sequencer, decoder and datapath:
// sequencer states, decoded instruction classes, trap causes and PC-select codes.
package rvm_control_seq_pkg;

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXECUTE    = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_MULDIV     = 4'd6,
    S_WB         = 4'd7,
    S_RETIRE     = 4'd8,
    S_TRAP       = 4'd9,
    S_HALT       = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_MULDIV  = 3'd5,
    CLS_SYSTEM  = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef enum logic [2:0] {
    CAUSE_ILLEGAL   = 3'd0,
    CAUSE_FETCH_ERR = 3'd1,
    CAUSE_DATA_ERR  = 3'd2,
    CAUSE_IRQ       = 3'd3,
    CAUSE_ECALL     = 3'd4
  } trap_cause_e;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_TARGET = 2'd1,
    PCSEL_TRAP   = 2'd2
  } pc_sel_e;

  function automatic logic is_wait(input state_e s);
    return (s == S_FETCH_WAIT) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/rvm_control_seq_wait_timer.sv
// rvm_wait_timer: wait-cycle counter shared by the fetch and data wait states.
//   clk, rst    : clock, async active-high reset
//   clr_i       : synchronous clear (held while not waiting, so it is zero on entry)
//   en_i        : count one wait cycle
//   cnt_o       : wait cycles already spent in the current wait
//   expired_o   : the current cycle is the LIMIT-th wait cycle (last one allowed)
module rvm_wait_timer #(
  parameter int TMO_W = 8,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [TMO_W-1:0] cnt_o,
  output logic             expired_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != '1) cnt_d = cnt_q + TMO_W'(1);  // saturate, never wrap
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/rvm_control_seq.sv
// rvm_control_seq: main control sequencer for the multi-cycle RISC-V core.
// Drives all datapath enables from the registered state, runs the memory
// req/ack handshake with a bounded wait, stalls on mul/div, samples irq and
// halt only at instruction boundaries, enters traps and counts retirements.
//   inputs : clk, reset, instr_class, branch_taken, mem_ack, mem_err,
//            muldiv_done, irq, halt_req
//   outputs: mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, muldiv_start,
//            trap_valid, trap_cause, halted, instret, state
module rvm_control_seq
  import rvm_control_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8,
  parameter int MULDIV_EN   = 1,
  parameter int IRQ_EN      = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       instr_class,
  input  logic             branch_taken,
  input  logic             mem_ack,
  input  logic             mem_err,
  input  logic             muldiv_done,
  input  logic             irq,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             muldiv_start,
  output logic             trap_valid,
  output logic [2:0]       trap_cause,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;
  pc_sel_e      pc_sel_q, pc_sel_d;
  trap_cause_e  cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             in_wait, tmr_expired, req_ok;
  logic [TMO_W-1:0] tmr_cnt;
  instr_class_e     cls_in;

  assign cls_in  = instr_class_e'(instr_class);
  assign in_wait = is_wait(state_q);
  // Belt-and-braces gate: the request can never outlive the timeout window.
  assign req_ok  = in_wait && (tmr_cnt < TMO_W'(MEM_TIMEOUT));

  rvm_wait_timer #(.TMO_W(TMO_W), .LIMIT(MEM_TIMEOUT)) u_tmr (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (!in_wait),
    .en_i      (in_wait),
    .cnt_o     (tmr_cnt),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      cls_q     <= CLS_ALU;
      pc_sel_q  <= PCSEL_SEQ;
      cause_q   <= CAUSE_ILLEGAL;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pc_sel_q  <= pc_sel_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    pc_sel_d     = pc_sel_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = pc_sel_q;
    rf_we        = 1'b0;
    muldiv_start = 1'b0;
    trap_valid   = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH_REQ;

      S_FETCH_REQ: begin
        if (halt_req) state_d = S_HALT;
        else if ((IRQ_EN != 0) && irq) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IRQ;
        end else state_d = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        mem_req = req_ok;
        ir_we   = mem_ack && !mem_err;
        // An ack on the last allowed cycle takes precedence over expiry.
        if (mem_ack) begin
          if (mem_err) begin
            state_d = S_TRAP;
            cause_d = CAUSE_FETCH_ERR;
          end else state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_FETCH_ERR;
        end
      end

      S_DECODE: state_d = S_EXECUTE;

      S_EXECUTE: begin
        // Latch the class for the data wait and the PC source for retire.
        cls_d    = cls_in;
        pc_sel_d = PCSEL_SEQ;
        case (cls_in)
          CLS_ALU:             state_d = S_WB;
          CLS_LOAD, CLS_STORE: state_d = S_MEM_WAIT;
          CLS_BRANCH: begin
            pc_sel_d = branch_taken ? PCSEL_TARGET : PCSEL_SEQ;
            state_d  = S_RETIRE;
          end
          CLS_JUMP: begin
            pc_sel_d = PCSEL_TARGET;
            state_d  = S_WB;
          end
          CLS_MULDIV: begin
            if (MULDIV_EN != 0) begin
              muldiv_start = 1'b1;
              state_d      = S_MULDIV;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          CLS_SYSTEM: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ECALL;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM_WAIT: begin
        mem_req = req_ok;
        mem_we  = req_ok && (cls_q == CLS_STORE);
        if (mem_ack) begin
          if (mem_err) begin
            state_d = S_TRAP;
            cause_d = CAUSE_DATA_ERR;
          end else state_d = (cls_q == CLS_LOAD) ? S_WB : S_RETIRE;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DATA_ERR;
        end
      end

      S_MULDIV: if (muldiv_done) state_d = S_WB;

      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_RETIRE;
      end

      S_RETIRE: begin
        pc_we     = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH_REQ;
      end

      S_TRAP: begin
        trap_valid = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = PCSEL_TRAP;
        state_d    = S_FETCH_REQ;
      end

      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = S_FETCH_REQ;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rvm_control_seq.sv
module tb_rvm_control_seq;
  import rvm_control_seq_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0, reset = 1'b1, rst_nm = 1'b1;
  logic [2:0] instr_class = '0;
  logic branch_taken = 0, mem_ack = 0, mem_err = 0, muldiv_done = 0, irq = 0, halt_req = 0;

  logic mem_req, mem_we, ir_we, pc_we, rf_we, muldiv_start, trap_valid, halted;
  logic [1:0] pc_sel;
  logic [2:0] trap_cause;
  logic [31:0] instret;
  logic [3:0] state;

  logic nm_req, nm_we, nm_irw, nm_pcw, nm_rfw, nm_mds, nm_tv, nm_hlt;
  logic [1:0] nm_psel;
  logic [2:0] nm_cause;
  logic [31:0] nm_ir;
  logic [3:0] nm_state;

  always #5 clk = ~clk;

  rvm_control_seq #(.MEM_TIMEOUT(TMO), .MULDIV_EN(1)) dut (
    .clk(clk), .reset(reset), .instr_class(instr_class), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .mem_err(mem_err), .muldiv_done(muldiv_done), .irq(irq),
    .halt_req(halt_req), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .muldiv_start(muldiv_start),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .halted(halted),
    .instret(instret), .state(state));

  rvm_control_seq #(.MEM_TIMEOUT(TMO), .MULDIV_EN(0)) dut_nm (
    .clk(clk), .reset(rst_nm), .instr_class(instr_class), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .mem_err(mem_err), .muldiv_done(muldiv_done), .irq(irq),
    .halt_req(halt_req), .mem_req(nm_req), .mem_we(nm_we), .ir_we(nm_irw),
    .pc_we(nm_pcw), .pc_sel(nm_psel), .rf_we(nm_rfw), .muldiv_start(nm_mds),
    .trap_valid(nm_tv), .trap_cause(nm_cause), .halted(nm_hlt),
    .instret(nm_ir), .state(nm_state));

  // One expected cycle: inputs to apply and outputs the sequencer must show.
  typedef struct {
    logic [3:0] st; logic [2:0] cls;
    logic taken, ack, err, done, irq, halt;
    logic req, we, irw, pcw; logic [1:0] psel;
    logic rfw, mds, tv; logic [2:0] cause; logic hlt; logic [31:0] ir;
  } cyc_t;

  cyc_t q[$];
  int unsigned m_instret = 0;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic cyc_t blank(input logic [3:0] st, input int cls);
    cyc_t c;
    c.st = st; c.cls = 3'(cls);
    c.taken = 0; c.ack = 0; c.err = 0; c.done = 0; c.irq = 0; c.halt = 0;
    c.req = 0; c.we = 0; c.irw = 0; c.pcw = 0; c.psel = 0;
    c.rfw = 0; c.mds = 0; c.tv = 0; c.cause = 0; c.hlt = 0; c.ir = m_instret;
    return c;
  endfunction

  task automatic push_trap(input int cls, input int cause);
    cyc_t c;
    c = blank(S_TRAP, cls); c.tv = 1; c.pcw = 1; c.psel = 2; c.cause = 3'(cause);
    q.push_back(c);
  endtask

  task automatic push_wb(input int cls);
    cyc_t c;
    c = blank(S_WB, cls); c.rfw = 1; q.push_back(c);
  endtask

  task automatic push_ret(input int cls, input int psel);
    cyc_t c;
    c = blank(S_RETIRE, cls); c.pcw = 1; c.psel = 2'(psel); q.push_back(c);
    m_instret++;
  endtask

  // Memory wait: request held each cycle until the ack (cycle ack_at) or
  // until TMO cycles have passed without one. ok=0 means the instruction traps.
  task automatic wait_phase(input int cls, input int ack_at, input bit err, input bit data, output bit ok);
    cyc_t c;
    ok = 0;
    for (int k = 1; k <= TMO; k++) begin
      c = blank(data ? S_MEM_WAIT : S_FETCH_WAIT, cls);
      c.req = 1; c.we = data && (cls == 2);
      if (k == ack_at) begin
        c.ack = 1; c.err = err; c.irw = !data && !err;
        q.push_back(c);
        ok = !err;
        return;
      end
      q.push_back(c);
    end
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic gen(input int cls, input int fack, input bit ferr, input int dack,
                     input bit derr, input int mdly, input bit taken);
    cyc_t c; bit ok;
    q.push_back(blank(S_FETCH_REQ, cls));
    wait_phase(cls, fack, ferr, 1'b0, ok);
    if (!ok) begin push_trap(cls, 1); return; end
    q.push_back(blank(S_DECODE, cls));
    c = blank(S_EXECUTE, cls); c.taken = taken; c.mds = (cls == 5); q.push_back(c);
    case (cls)
      0: begin push_wb(cls); push_ret(cls, 0); end
      1, 2: begin
        wait_phase(cls, dack, derr, 1'b1, ok);
        if (!ok) begin push_trap(cls, 2); return; end
        if (cls == 1) push_wb(cls);
        push_ret(cls, 0);
      end
      3: push_ret(cls, taken ? 1 : 0);
      4: begin push_wb(cls); push_ret(cls, 1); end
      5: begin
        for (int k = 1; k <= mdly; k++) begin
          c = blank(S_MULDIV, cls); c.done = (k == mdly); q.push_back(c);
        end
        push_wb(cls); push_ret(cls, 0);
      end
      6: push_trap(cls, 4);
      default: push_trap(cls, 0);
    endcase
  endtask

  // halt_req and irq together: halt wins; after release the irq is taken.
  task automatic gen_halt_irq();
    cyc_t c;
    c = blank(S_FETCH_REQ, 0); c.halt = 1; c.irq = 1; q.push_back(c);
    for (int k = 0; k < 3; k++) begin
      c = blank(S_HALT, 0); c.halt = 1; c.irq = 1; c.hlt = 1; q.push_back(c);
    end
    c = blank(S_HALT, 0); c.irq = 1; c.hlt = 1; q.push_back(c);
    c = blank(S_FETCH_REQ, 0); c.irq = 1; q.push_back(c);
    push_trap(0, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int run, max_run, md_cyc, md_pulses, traps;
    run = 0; max_run = 0; md_cyc = 0; md_pulses = 0; traps = 0;

    q.push_back(blank(S_RESET, 0));
    gen(0, 2, 0, 0, 0, 0, 0);    // ALU, fetch ack on 2nd wait cycle
    gen(1, 1, 0, 3, 1, 0, 0);    // LOAD, data error
    gen(0, 0, 0, 0, 0, 0, 0);    // fetch timeout
    gen(0, TMO, 0, 0, 0, 0, 0);  // ack on the final allowed cycle
    gen(1, 1, 0, 2, 0, 0, 0);    // LOAD ok
    gen(2, 1, 0, 1, 0, 0, 0);    // STORE ok
    gen(3, 1, 0, 0, 0, 0, 1);    // BRANCH taken
    gen(3, 3, 0, 0, 0, 0, 0);    // BRANCH not taken
    gen(4, 1, 0, 0, 0, 0, 0);    // JUMP
    gen(5, 1, 0, 0, 0, 7, 0);    // MULDIV, done after 7 cycles
    gen(6, 1, 0, 0, 0, 0, 0);    // SYSTEM
    gen(7, 2, 0, 0, 0, 0, 0);    // ILLEGAL
    gen(2, 1, 0, 0, 0, 0, 0);    // STORE, data timeout
    gen_halt_irq();
    gen(0, 2, 1, 0, 0, 0, 0);    // fetch bus error

    @(negedge clk); @(negedge clk); #1;
    chk("rst_state", -1, 32'(state), 32'(S_RESET));
    chk("rst_outs", -1, {22'd0, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, muldiv_start, trap_valid, halted}, 32'd0);
    chk("rst_cause", -1, 32'(trap_cause), 32'd0);
    chk("rst_instret", -1, instret, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      instr_class = q[i].cls; branch_taken = q[i].taken; mem_ack = q[i].ack;
      mem_err = q[i].err; muldiv_done = q[i].done; irq = q[i].irq; halt_req = q[i].halt;
      #1;
      chk("state", i, 32'(state), 32'(q[i].st));
      chk("mem_req", i, 32'(mem_req), 32'(q[i].req));
      chk("mem_we", i, 32'(mem_we), 32'(q[i].we));
      chk("ir_we", i, 32'(ir_we), 32'(q[i].irw));
      chk("pc_we", i, 32'(pc_we), 32'(q[i].pcw));
      chk("rf_we", i, 32'(rf_we), 32'(q[i].rfw));
      chk("muldiv_start", i, 32'(muldiv_start), 32'(q[i].mds));
      chk("trap_valid", i, 32'(trap_valid), 32'(q[i].tv));
      chk("halted", i, 32'(halted), 32'(q[i].hlt));
      chk("instret", i, instret, q[i].ir);
      if (q[i].pcw) chk("pc_sel", i, 32'(pc_sel), 32'(q[i].psel));
      if (q[i].tv)  chk("trap_cause", i, 32'(trap_cause), 32'(q[i].cause));
      run = mem_req ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (state == S_MULDIV) md_cyc++;
      if (muldiv_start) md_pulses++;
      if (trap_valid) traps++;
      @(negedge clk);
    end

    // Hand-computed totals for the directed program above.
    #1;
    chk("final_instret", -1, instret, 32'd8);
    chk("max_mem_req_run", -1, 32'(max_run), 32'd15);
    chk("muldiv_cycles", -1, 32'(md_cyc), 32'd7);
    chk("muldiv_start_pulses", -1, 32'(md_pulses), 32'd1);
    chk("trap_count", -1, 32'(traps), 32'd7);

    // MULDIV_EN=0 instance: MULDIV class must become an illegal-instruction trap.
    reset = 1'b1;
    instr_class = 3'd5; branch_taken = 0; mem_err = 0; muldiv_done = 0; irq = 0; halt_req = 0;
    rst_nm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_ack = (k == 2);
      #1;
      if (k == 4) begin
        chk("nm_exec_state", k, 32'(nm_state), 32'(S_EXECUTE));
        chk("nm_muldiv_start", k, 32'(nm_mds), 32'd0);
      end
      if (k == 5) begin
        chk("nm_trap_state", k, 32'(nm_state), 32'(S_TRAP));
        chk("nm_trap_valid", k, 32'(nm_tv), 32'd1);
        chk("nm_trap_cause", k, 32'(nm_cause), 32'd0);
      end
      @(negedge clk);
    end
    mem_ack = 0;

    // Reset asserted in the middle of a fetch wait.
    rst_nm = 1'b1; instr_class = 3'd0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("pre_rst_state", -1, 32'(state), 32'(S_FETCH_WAIT));
    chk("pre_rst_mem_req", -1, 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_req", -1, 32'(mem_req), 32'd0);
    chk("async_rst_state", -1, 32'(state), 32'(S_RESET));
    chk("async_rst_instret", -1, instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
